// File: rtl/wb_write_buffer.sv
// Posted-write buffer between a cache outbus and a pipelined Wishbone memory port.
// Writes are acknowledged as soon as they land in a DEPTH-entry FIFO and are
// drained to memory one at a time; reads wait until the FIFO is empty and then
// run a single memory read, so a read never overtakes an earlier posted write.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   in_*                upstream pipelined Wishbone slave (adr/cyc/stb/we/sel/dat in,
//                       ack/stall/dat out); in_stall_o is combinational
//   out_*               memory-side pipelined Wishbone master
//   wbuf_count_o        FIFO occupancy, 0..DEPTH
module wb_write_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned AWIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [AWIDTH-1:0]        in_adr_i,
  input  logic                     in_cyc_i,
  input  logic                     in_stb_i,
  input  logic                     in_we_i,
  input  logic [3:0]               in_sel_i,
  input  logic [31:0]              in_dat_i,
  output logic                     in_ack_o,
  output logic                     in_stall_o,
  output logic [31:0]              in_dat_o,
  output logic [AWIDTH-1:0]        out_adr_o,
  output logic                     out_cyc_o,
  output logic                     out_stb_o,
  output logic                     out_we_o,
  output logic [3:0]               out_sel_o,
  output logic [31:0]              out_dat_o,
  input  logic                     out_ack_i,
  input  logic                     out_stall_i,
  input  logic [31:0]              out_dat_i,
  output logic [$clog2(DEPTH):0]   wbuf_count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [AWIDTH-1:0] adr;
    logic [3:0]        sel;
    logic [31:0]       dat;
  } entry_t;

  typedef enum logic [2:0] {IDLE, WRITE, WWAIT, READ, RWAIT, RDONE} state_t;

  state_t        state;
  entry_t        mem [DEPTH];
  entry_t        in_entry;
  entry_t        next_head;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_nxt;
  logic [CW-1:0] count_nxt;
  logic          full;
  logic          rd_busy;
  logic          push;
  logic          pop;
  logic          rd_acc;

  assign in_entry = {in_adr_i, in_sel_i, in_dat_i};
  assign full     = (wbuf_count_o == CW'(DEPTH));
  assign rd_busy  = (state == READ) || (state == RWAIT) || (state == RDONE);

  // A read is held off while anything is buffered or the memory port is busy.
  assign in_stall_o = full | rd_busy |
                      (in_stb_i & ~in_we_i & ((wbuf_count_o != '0) | (state != IDLE)));

  assign push   = in_cyc_i & in_stb_i & in_we_i & ~in_stall_o;
  assign rd_acc = in_cyc_i & in_stb_i & ~in_we_i & ~in_stall_o;
  assign pop    = (state == WWAIT) & out_ack_i;
  assign rd_nxt = rd_ptr + PW'(1);

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_nxt = wbuf_count_o;
    if (push && !pop) begin
      count_nxt = wbuf_count_o + CW'(1);
    end else if (pop && !push) begin
      count_nxt = wbuf_count_o - CW'(1);
    end
  end

  // Head after a pop; forward the incoming entry when it lands in that very slot.
  always_comb begin
    next_head = mem[rd_nxt];
    if (push && (wr_ptr == rd_nxt)) begin
      next_head = in_entry;
    end
  end

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= in_entry;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      wbuf_count_o <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_nxt;
      end
      wbuf_count_o <= count_nxt;
    end
  end

  // Memory-side sequencer with registered bus outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      in_ack_o  <= 1'b0;
      in_dat_o  <= '0;
      out_adr_o <= '0;
      out_cyc_o <= 1'b0;
      out_stb_o <= 1'b0;
      out_we_o  <= 1'b0;
      out_sel_o <= '0;
      out_dat_o <= '0;
    end else begin
      in_ack_o <= push;
      case (state)
        IDLE: begin
          if (wbuf_count_o != '0) begin
            state     <= WRITE;
            out_cyc_o <= 1'b1;
            out_stb_o <= 1'b1;
            out_we_o  <= 1'b1;
            {out_adr_o, out_sel_o, out_dat_o} <= mem[rd_ptr];
          end else if (rd_acc) begin
            state     <= READ;
            out_cyc_o <= 1'b1;
            out_stb_o <= 1'b1;
            out_we_o  <= 1'b0;
            out_adr_o <= in_adr_i;
            out_sel_o <= in_sel_i;
          end
        end
        WRITE: begin
          if (!out_stall_i) begin
            state     <= WWAIT;
            out_stb_o <= 1'b0;
          end
        end
        WWAIT: begin
          if (out_ack_i) begin
            if (count_nxt != '0) begin
              state     <= WRITE;
              out_stb_o <= 1'b1;
              {out_adr_o, out_sel_o, out_dat_o} <= next_head;
            end else begin
              state     <= IDLE;
              out_cyc_o <= 1'b0;
              out_we_o  <= 1'b0;
            end
          end
        end
        READ: begin
          if (!out_stall_i) begin
            state     <= RWAIT;
            out_stb_o <= 1'b0;
          end
        end
        RWAIT: begin
          // The read ack is only returned if the requester still holds its cycle.
          if (out_ack_i) begin
            state     <= RDONE;
            in_dat_o  <= out_dat_i;
            in_ack_o  <= in_cyc_i;
            out_cyc_o <= 1'b0;
          end
        end
        RDONE: begin
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          out_cyc_o <= 1'b0;
          out_stb_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/wb_write_buffer.md
WB_WRITE_BUFFER -- requirements
Module: wb_write_buffer

Interface
REQ-001 Parameter: DEPTH, 4, number of posted-write entries (power of 2, >=2).
REQ-002 Parameter: AWIDTH, 32, address width.
REQ-003 clk_i  in  1  single clock; all state changes on rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-high.
REQ-005 in_adr_i  in  AWIDTH  upstream (cache outbus) address.
REQ-006 in_cyc_i / in_stb_i / in_we_i  in  1 each  upstream cycle, strobe, write enable.
REQ-007 in_sel_i  in  4  upstream byte selects.
REQ-008 in_dat_i  in  32  upstream write data.
REQ-009 in_ack_o / in_stall_o  out  1 each  upstream acknowledge, pipelined stall.
REQ-010 in_dat_o  out  32  upstream read data.
REQ-011 out_adr_o  out  AWIDTH  memory-side address.
REQ-012 out_cyc_o / out_stb_o / out_we_o  out  1 each  memory-side cycle, strobe, write enable.
REQ-013 out_sel_o  out  4  memory-side byte selects.
REQ-014 out_dat_o  out  32  memory-side write data.
REQ-015 out_ack_i / out_stall_i  in  1 each  memory-side acknowledge, stall.
REQ-016 out_dat_i  in  32  memory-side read data.
REQ-017 wbuf_count_o  out  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-018 FIFO entry = {adr, sel, dat}; circular read/write pointers wrap at DEPTH; count range 0..DEPTH.
REQ-019 Write accept = in_cyc_i & in_stb_i & in_we_i & !in_stall_o; pushes entry; in_ack_o=1 exactly one cycle later, once per accepted write.
REQ-020 in_stall_o = (count==DEPTH) | state in {READ, RWAIT, RDONE} | (in_stb_i & !in_we_i & (count!=0 | state!=IDLE)); combinational.
REQ-021 Read accept = in_cyc_i & in_stb_i & !in_we_i & !in_stall_o; only possible with FIFO empty and state IDLE (reads never bypass posted writes); latches adr/sel.
REQ-022 FSM states IDLE, WRITE, WWAIT, READ, RWAIT, RDONE.
REQ-023 IDLE: count!=0 -> WRITE; else read accept -> READ; else stay.
REQ-024 WRITE: out_cyc_o=out_stb_o=out_we_o=1 driving FIFO head; !out_stall_i -> WWAIT.
REQ-025 WWAIT: out_cyc_o=1, out_stb_o=0; on out_ack_i pop head; then count-after-pop!=0 -> WRITE else IDLE.
REQ-026 READ: out_cyc_o=out_stb_o=1, out_we_o=0, latched adr/sel; !out_stall_i -> RWAIT.
REQ-027 RWAIT: out_cyc_o=1; on out_ack_i capture out_dat_i into in_dat_o -> RDONE.
REQ-028 RDONE: in_ack_o=1 for one cycle if in_cyc_i still high, else suppressed; -> IDLE.
REQ-029 At most one memory-side transaction outstanding; out_cyc_o=0 in IDLE and RDONE.
REQ-030 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-031 Push when count==DEPTH is impossible (stalled); pop only from WWAIT with count>=1.
REQ-032 in_cyc_i deassertion never discards accepted writes; FIFO drains to empty.
REQ-033 out_ack_i outside WWAIT/RWAIT ignored.
REQ-034 in_dat_o holds last captured read data until next capture.

Reset
REQ-035 rst_i=1 asynchronously: state=IDLE, pointers=0, count=0, all outputs 0 (including in_stall_o, in_dat_o, wbuf_count_o).
REQ-036 Reset mid-transaction abandons FIFO contents and any in-flight memory cycle; no ack issued.

Verification
REQ-037 Single write 0x100/0xDEADBEEF, sel=0xF, memory no-stall, ack next cycle -> in_ack_o cycle+1; out write to 0x100 with same data; count 1->0.
REQ-038 DEPTH=4, 5 back-to-back writes, out_stall_i=1 -> writes 1-4 acked, 5th stalled while count==4; release stall -> 5th accepted on first pop, memory sees all 5 in order.
REQ-039 Write 0x200=0x11 then read 0x200 -> read stalled until count==0 and IDLE; memory sees write before read; in_dat_o=out_dat_i, in_ack_o in RDONE.
REQ-040 Pop and push same cycle at count==2 -> count stays 2, pointers wrap past DEPTH-1 correctly over 10 writes.
REQ-041 Read issued, in_cyc_i dropped in RWAIT -> memory cycle completes, in_ack_o never asserted, returns IDLE.
REQ-042 rst_i asserted in WWAIT with count==3 -> out_cyc_o=0 immediately, count=0, no in_ack_o.
